// File: rtl/ecc_event_logger.sv
// Hamming syndrome event logger: classifies per-block syndromes in hold
// windows, queues one event record per window and keeps saturating stats.
module ecc_event_logger #(
  parameter int width       = 128,
  parameter int blocks      = width / 4,
  parameter int parity_bits = blocks * 3,
  parameter int depth       = 8,
  parameter int cnt_w       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     error_detected,
  input  logic [parity_bits-1:0]   syndrome,
  input  logic [width-1:0]         counter,
  input  logic                     clear_counts,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [width-1:0]         evt_counter,
  output logic [blocks-1:0]        evt_corr_mask,
  output logic [blocks-1:0]        evt_par_mask,
  output logic                     evt_overflow,
  output logic [$clog2(depth):0]   fifo_level,
  output logic [cnt_w-1:0]         corr_count,
  output logic [cnt_w-1:0]         par_count,
  output logic [cnt_w-1:0]         drop_count
);

  localparam int aw = $clog2(depth);
  localparam int lw = aw + 1;
  localparam int sw = cnt_w + $clog2(blocks) + 1;

  typedef struct packed {
    logic [width-1:0]  cnt;
    logic [blocks-1:0] corr;
    logic [blocks-1:0] par;
    logic              ovf;
  } rec_t;

  typedef enum logic {
    ARMED,
    CAPTURED
  } state_t;

  state_t state_q, state_d;

  logic [blocks-1:0] corr_mask;
  logic [blocks-1:0] par_mask;
  logic              capture;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic              ovf_pending;

  rec_t              mem [depth];
  rec_t              head;
  logic [aw-1:0]     wr_ptr;
  logic [aw-1:0]     rd_ptr;

  function automatic logic [sw-1:0] popcnt(
    input logic [blocks-1:0] m
  );
    logic [sw-1:0] n;
    n = '0;
    for (int i = 0; i < blocks; i++)
      n = n + sw'(m[i]);
    return n;
  endfunction

  function automatic logic [cnt_w-1:0] sat_add(
    input logic [cnt_w-1:0] a,
    input logic [sw-1:0]    b
  );
    logic [sw-1:0] s;
    s = sw'(a) + b;
    if (s > sw'({cnt_w{1'b1}}))
      return {cnt_w{1'b1}};
    return s[cnt_w-1:0];
  endfunction

  // Two or more syndrome bits set point at a data bit, one at a parity bit.
  always_comb begin
    corr_mask = '0;
    par_mask  = '0;
    for (int i = 0; i < blocks; i++) begin
      logic [2:0] s;
      s = syndrome[i*3 +: 3];
      corr_mask[i] = (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
      par_mask[i]  = (s != 3'b000) & ~corr_mask[i];
    end
  end

  assign capture = (state_q == ARMED) && !enable && error_detected
                   && ((corr_mask | par_mask) != '0);
  assign evt_valid = (fifo_level != '0);
  assign pop       = evt_valid && evt_ready;
  assign push_ok   = capture && ((fifo_level < lw'(depth)) || pop);
  assign drop      = capture && !push_ok;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARMED:    if (capture) state_d = CAPTURED;
      CAPTURED: if (enable)  state_d = ARMED;
      default:  state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ARMED;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= '{cnt:  counter,
                       corr: corr_mask,
                       par:  par_mask,
                       ovf:  ovf_pending};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      ovf_pending <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + lw'(push_ok) - lw'(pop);
      if (push_ok)   ovf_pending <= 1'b0;
      else if (drop) ovf_pending <= 1'b1;
    end
  end

  assign head          = mem[rd_ptr];
  assign evt_counter   = evt_valid ? head.cnt  : '0;
  assign evt_corr_mask = evt_valid ? head.corr : '0;
  assign evt_par_mask  = evt_valid ? head.par  : '0;
  assign evt_overflow  = evt_valid ? head.ovf  : 1'b0;

  // Clear beats same-edge increments; dropped events still count.
  always_ff @(posedge clk) begin
    if (!reset || clear_counts) begin
      corr_count <= '0;
      par_count  <= '0;
      drop_count <= '0;
    end else begin
      if (capture) begin
        corr_count <= sat_add(corr_count, popcnt(corr_mask));
        par_count  <= sat_add(par_count, popcnt(par_mask));
      end
      if (drop && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ecc_event_logger.sv
// Directed bench for ecc_event_logger (cnt_w=4 so saturation is reachable).
module tb_ecc_event_logger;

  localparam int W  = 128;
  localparam int B  = W / 4;
  localparam int P  = B * 3;
  localparam int D  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          error_detected;
  logic [P-1:0]  syndrome;
  logic [W-1:0]  counter;
  logic          clear_counts;
  logic          evt_ready;
  logic          evt_valid;
  logic [W-1:0]  evt_counter;
  logic [B-1:0]  evt_corr_mask;
  logic [B-1:0]  evt_par_mask;
  logic          evt_overflow;
  logic [3:0]    fifo_level;
  logic [CW-1:0] corr_count;
  logic [CW-1:0] par_count;
  logic [CW-1:0] drop_count;

  int errors = 0;
  int checks = 0;

  ecc_event_logger #(
    .width(W), .depth(D), .cnt_w(CW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .error_detected(error_detected), .syndrome(syndrome),
    .counter(counter), .clear_counts(clear_counts),
    .evt_ready(evt_ready), .evt_valid(evt_valid),
    .evt_counter(evt_counter), .evt_corr_mask(evt_corr_mask),
    .evt_par_mask(evt_par_mask), .evt_overflow(evt_overflow),
    .fifo_level(fifo_level), .corr_count(corr_count),
    .par_count(par_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One hold window: capture edge (optionally popping), then re-arm edge.
  task automatic window(input logic [W-1:0] c,
                        input logic [P-1:0] s,
                        input logic pop);
    enable = 1'b0; error_detected = 1'b1;
    counter = c; syndrome = s; evt_ready = pop;
    tick();
    enable = 1'b1; error_detected = 1'b0;
    evt_ready = 1'b0; syndrome = '0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; error_detected = 1'b0;
    syndrome = '0; counter = '0; clear_counts = 1'b0;
    evt_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b0 || fifo_level !== 4'd0) begin
      errors++;
      $display("FAIL reset_fifo: valid=%0b level=%0d want 0 0",
               evt_valid, fifo_level);
    end
    checks++;
    if (corr_count !== 0 || par_count !== 0 || drop_count !== 0) begin
      errors++;
      $display("FAIL reset_counts: %0d %0d %0d want 0 0 0",
               corr_count, par_count, drop_count);
    end
    checks++;
    if (evt_counter !== '0 || evt_corr_mask !== '0 || evt_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: cnt=%0h corr=%0h ovf=%0b want 0",
               evt_counter, evt_corr_mask, evt_overflow);
    end
  endtask

  task automatic test_single();
    enable = 1'b0; error_detected = 1'b1; syndrome = '0;
    counter = 128'h1234;
    tick();
    checks++;
    if (fifo_level !== 4'd0 || corr_count !== 0) begin
      errors++;
      $display("FAIL zero_mask: level=%0d corr=%0d want 0 0",
               fifo_level, corr_count);
    end
    syndrome[2:0] = 3'b011;
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_counter !== 128'h1234) begin
      errors++;
      $display("FAIL single_evt: valid=%0b cnt=%0h want 1 1234",
               evt_valid, evt_counter);
    end
    checks++;
    if (evt_corr_mask !== 32'h1 || evt_par_mask !== 32'h0
        || corr_count !== 4'd1) begin
      errors++;
      $display("FAIL single_mask: corr=%0h par=%0h cc=%0d want 1 0 1",
               evt_corr_mask, evt_par_mask, corr_count);
    end
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (fifo_level !== 4'd1 || corr_count !== 4'd1) begin
      errors++;
      $display("FAIL one_per_window: level=%0d cc=%0d want 1 1",
               fifo_level, corr_count);
    end
    enable = 1'b1;
    tick();
    enable = 1'b0; counter = 128'h5678;
    tick();
    checks++;
    if (fifo_level !== 4'd2 || corr_count !== 4'd2) begin
      errors++;
      $display("FAIL second_window: level=%0d cc=%0d want 2 2",
               fifo_level, corr_count);
    end
    enable = 1'b1; error_detected = 1'b0; syndrome = '0;
    evt_ready = 1'b1;
    tick();
    checks++;
    if (evt_counter !== 128'h5678 || fifo_level !== 4'd1) begin
      errors++;
      $display("FAIL pop_next: cnt=%0h level=%0d want 5678 1",
               evt_counter, fifo_level);
    end
    tick(); tick();
    checks++;
    if (evt_valid !== 1'b0 || fifo_level !== 4'd0 || evt_counter !== '0) begin
      errors++;
      $display("FAIL empty_ready: valid=%0b level=%0d cnt=%0h want 0 0 0",
               evt_valid, fifo_level, evt_counter);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_mixed();
    logic [P-1:0] s;
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    checks++;
    if (corr_count !== 0 || par_count !== 0) begin
      errors++;
      $display("FAIL clear: cc=%0d pc=%0d want 0 0", corr_count, par_count);
    end
    s = '0;
    s[3*3 +: 3] = 3'b100;
    s[5*3 +: 3] = 3'b111;
    enable = 1'b0; error_detected = 1'b1; counter = 128'hABC; syndrome = s;
    tick();
    checks++;
    if (evt_par_mask !== 32'h08 || evt_corr_mask !== 32'h20) begin
      errors++;
      $display("FAIL mixed_mask: par=%0h corr=%0h want 08 20",
               evt_par_mask, evt_corr_mask);
    end
    checks++;
    if (par_count !== 4'd1 || corr_count !== 4'd1) begin
      errors++;
      $display("FAIL mixed_count: pc=%0d cc=%0d want 1 1",
               par_count, corr_count);
    end
    enable = 1'b1; error_detected = 1'b0; syndrome = '0; evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [P-1:0] s;
    logic [W-1:0] want;
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    s = '0;
    s[2:0] = 3'b001;
    for (int i = 1; i <= 9; i++) window(W'(i), s, 1'b0);
    checks++;
    if (fifo_level !== 4'd8 || drop_count !== 4'd1) begin
      errors++;
      $display("FAIL full_drop: level=%0d drop=%0d want 8 1",
               fifo_level, drop_count);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    window(W'(10), s, 1'b0);
    checks++;
    if (fifo_level !== 4'd8 || par_count !== 4'd10) begin
      errors++;
      $display("FAIL refill: level=%0d pc=%0d want 8 10",
               fifo_level, par_count);
    end
    for (int i = 2; i <= 9; i++) begin
      want = (i == 9) ? W'(10) : W'(i);
      checks++;
      if (evt_counter !== want || evt_overflow !== (i == 9)) begin
        errors++;
        $display("FAIL ovf_entry%0d: cnt=%0d ovf=%0b want %0d %0b",
                 i, evt_counter, evt_overflow, want, (i == 9));
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    checks++;
    if (fifo_level !== 4'd0) begin
      errors++;
      $display("FAIL drained: level=%0d want 0", fifo_level);
    end
  endtask

  task automatic test_saturation();
    logic [P-1:0] s3;
    logic [P-1:0] s2;
    logic [P-1:0] s1;
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    s3 = '0;
    s3[8:0] = {3'b110, 3'b101, 3'b011};
    s2 = '0;
    s2[5:0] = {3'b111, 3'b011};
    s1 = '0;
    s1[2:0] = 3'b110;
    for (int i = 0; i < 4; i++) window(W'(20 + i), s3, 1'b0);
    window(W'(24), s2, 1'b0);
    checks++;
    if (corr_count !== 4'd14) begin
      errors++;
      $display("FAIL preload: cc=%0d want 14", corr_count);
    end
    window(W'(25), s3, 1'b0);
    checks++;
    if (corr_count !== 4'd15 || drop_count !== 4'd0) begin
      errors++;
      $display("FAIL saturate: cc=%0d drop=%0d want 15 0",
               corr_count, drop_count);
    end
    enable = 1'b0; error_detected = 1'b1; syndrome = s3;
    counter = W'(26); clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    checks++;
    if (corr_count !== 0 || par_count !== 0 || fifo_level !== 4'd7) begin
      errors++;
      $display("FAIL clear_wins: cc=%0d pc=%0d level=%0d want 0 0 7",
               corr_count, par_count, fifo_level);
    end
    enable = 1'b1; error_detected = 1'b0; syndrome = '0;
    tick();
    window(W'(27), s1, 1'b0);
    window(W'(28), s3, 1'b1);
    checks++;
    if (fifo_level !== 4'd8 || drop_count !== 4'd0 || corr_count !== 4'd4) begin
      errors++;
      $display("FAIL full_pop_push: level=%0d drop=%0d cc=%0d want 8 0 4",
               fifo_level, drop_count, corr_count);
    end
    checks++;
    if (evt_counter !== W'(21)) begin
      errors++;
      $display("FAIL full_pop_head: cnt=%0d want 21", evt_counter);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (evt_valid !== 1'b0 || fifo_level !== 4'd0 || corr_count !== 0) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b level=%0d cc=%0d want 0 0 0",
               evt_valid, fifo_level, corr_count);
    end
    window(W'(99), {{(P-3){1'b0}}, 3'b010}, 1'b0);
    checks++;
    if (fifo_level !== 4'd1 || evt_par_mask !== 32'h1 || par_count !== 4'd1) begin
      errors++;
      $display("FAIL rearm_after_reset: level=%0d par=%0h pc=%0d want 1 1 1",
               fifo_level, evt_par_mask, par_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mixed();
    test_overflow();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
